mem_port_arbiter: RTL and testbench

Shares the CPU's single-port unified instruction/data memory between two requesters: the instruction-fetch unit (I) and the load/store unit (D).
- Sits between those two units and the memory macro inside cpu_top.
- Grants one transaction at a time and registers the address/data onto the memory port.
- Returns read data and an ack pulse to the winning requester.
- Data accesses have priority, with an anti-starvation limit for fetch.
- A halt input blocks new fetches once the CPU reaches HALT.

---
 rtl/mem_port_arbiter_pkg.sv | 23 ++
 rtl/mem_port_arbiter_prio_sel.sv | 24 ++
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the I/D memory-port arbiter: FSM states and grant encodings.
`default_nettype none

package mem_port_arbiter_pkg;

   localparam int ARB_ADDR_W = 16;
   localparam int ARB_DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      GNT_NONE = 2'd0,
      GNT_I    = 2'd1,
      GNT_D    = 2'd2
   } arb_grant_e;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_prio_sel.sv
// Combinational grant decision: data first, unless fetch has waited out its D streak.
`default_nettype none

module mem_port_arbiter_prio_sel
   import mem_port_arbiter_pkg::*;
(
   input  logic       d_req,
   input  logic       eff_i,
   input  logic       streak_at_max,
   output arb_grant_e grant
);

   always_comb begin
      grant = GNT_NONE;
      if (d_req && !(eff_i && streak_at_max)) begin
         grant = GNT_D;
      end else if (eff_i) begin
         grant = GNT_I;
      end
   end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified memory between instruction fetch (I) and load/store (D).
`default_nettype none

module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W       = ARB_ADDR_W,
   parameter int DATA_W       = ARB_DATA_W,
   parameter int MAX_D_STREAK = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              halt,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_done,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              err_spurious
);

   localparam int                  STREAK_W   = $clog2(MAX_D_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

   arb_state_e          state, state_nxt;
   logic [STREAK_W-1:0] streak, streak_nxt;
   arb_grant_e          grant_raw, grant;
   logic                eff_i;
   logic                streak_at_max;
   logic                ack_cycle;

   assign eff_i         = i_req & ~halt;
   assign streak_at_max = (streak == STREAK_MAX);
   // Requesters drop req only after seeing ack, so the ack cycle never grants.
   assign ack_cycle     = i_ack | d_ack;
   assign busy          = (state != IDLE);

   mem_port_arbiter_prio_sel u_prio_sel (
      .d_req         (d_req),
      .eff_i         (eff_i),
      .streak_at_max (streak_at_max),
      .grant         (grant_raw)
   );

   assign grant = (state == IDLE && !ack_cycle) ? grant_raw : GNT_NONE;

   always_comb begin
      state_nxt  = state;
      streak_nxt = streak;
      case (state)
         IDLE: begin
            case (grant)
               GNT_D: begin
                  state_nxt = BUSY_D;
                  if (!eff_i) begin
                     streak_nxt = '0;
                  end else if (!streak_at_max) begin
                     streak_nxt = streak + STREAK_W'(1);
                  end
               end
               GNT_I: begin
                  state_nxt  = BUSY_I;
                  streak_nxt = '0;
               end
               default: ;
            endcase
         end
         BUSY_I, BUSY_D: begin
            if (mem_done) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         streak       <= '0;
         mem_req      <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         i_ack        <= 1'b0;
         d_ack        <= 1'b0;
         i_rdata      <= '0;
         d_rdata      <= '0;
         err_spurious <= 1'b0;
      end else begin
         state  <= state_nxt;
         streak <= streak_nxt;
         i_ack  <= 1'b0;
         d_ack  <= 1'b0;

         case (grant)
            GNT_I: begin
               mem_req  <= 1'b1;
               mem_we   <= 1'b0;
               mem_addr <= i_addr;
            end
            GNT_D: begin
               mem_req   <= 1'b1;
               mem_we    <= d_we;
               mem_addr  <= d_addr;
               mem_wdata <= d_wdata;
            end
            default: ;
         endcase

         if (mem_done) begin
            case (state)
               BUSY_I: begin
                  i_rdata <= mem_rdata;
                  i_ack   <= 1'b1;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end
               BUSY_D: begin
                  if (!mem_we) begin
                     d_rdata <= mem_rdata;
                  end
                  d_ack   <= 1'b1;
                  mem_req <= 1'b0;
                  mem_we  <= 1'b0;
               end
               default: err_spurious <= 1'b1;
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a 1-cycle-latency memory model.
`default_nettype none

module tb_mem_port_arbiter;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
   } iss_t;

   typedef struct {
      bit          is_d;
      logic [15:0] data;
   } rsp_t;

   logic        clk = 1'b0;
   logic        reset, halt;
   logic        i_req, d_req, d_we, mem_done;
   logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic        i_ack, d_ack, mem_req, mem_we, busy, err_spurious;
   logic [15:0] i_rdata, d_rdata, mem_addr, mem_wdata;

   int   n_cmp  = 0;
   int   n_fail = 0;
   iss_t issue_q[$];
   rsp_t resp_q[$];
   logic [15:0] mem [logic [15:0]];
   bit   mem_auto = 1'b1;

   mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_D_STREAK(2)) dut (
      .clk(clk), .reset(reset), .halt(halt),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_done(mem_done), .mem_rdata(mem_rdata),
      .busy(busy), .err_spurious(err_spurious)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] rd(input logic [15:0] a);
      if (mem.exists(a)) return mem[a];
      return 16'hDEAD;
   endfunction

   // Memory model: mem_done one cycle after mem_req is first seen.
   initial begin
      int lat;
      lat       = 0;
      mem_done  = 1'b0;
      mem_rdata = 16'h0000;
      forever begin
         @(posedge clk); #1;
         if (mem_done) begin
            mem_done = 1'b0;
            lat      = 0;
         end else if (mem_auto && mem_req) begin
            if (lat == 1) begin
               mem_done = 1'b1;
               if (mem_we) mem[mem_addr] = mem_wdata;
               else        mem_rdata = rd(mem_addr);
               lat = 0;
            end else begin
               lat++;
            end
         end else begin
            lat = 0;
         end
      end
   end

   // Monitor: checks each new memory issue and each ack against the queues.
   initial begin
      logic prev_req;
      iss_t e;
      rsp_t r;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (mem_req && !prev_req) begin
            n_cmp++;
            if (issue_q.size() == 0) begin
               n_fail++;
               $display("FAIL issue: got unexpected issue addr=%h we=%0b, want none", mem_addr, mem_we);
            end else begin
               e = issue_q.pop_front();
               if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.wdata)) begin
                  n_fail++;
                  $display("FAIL issue: got we=%0b addr=%h wdata=%h, want we=%0b addr=%h wdata=%h",
                           mem_we, mem_addr, mem_wdata, e.we, e.addr, e.wdata);
               end
            end
         end
         prev_req = mem_req;
         if (i_ack || d_ack) begin
            n_cmp++;
            if (i_ack && d_ack) begin
               n_fail++;
               $display("FAIL ack: got i_ack=1 d_ack=1, want one ack");
            end else if (resp_q.size() == 0) begin
               n_fail++;
               $display("FAIL ack: got unexpected ack i=%0b d=%0b, want none", i_ack, d_ack);
            end else begin
               r = resp_q.pop_front();
               if (r.is_d != d_ack) begin
                  n_fail++;
                  $display("FAIL ack: got d_ack=%0b, want d_ack=%0b", d_ack, r.is_d);
               end else if (r.is_d && d_rdata !== r.data) begin
                  n_fail++;
                  $display("FAIL d_rdata: got %h, want %h", d_rdata, r.data);
               end else if (!r.is_d && i_rdata !== r.data) begin
                  n_fail++;
                  $display("FAIL i_rdata: got %h, want %h", i_rdata, r.data);
               end
            end
         end
      end
   end

   task automatic expect_issue(input logic we, input logic [15:0] a, input logic [15:0] wd);
      iss_t e;
      e.we = we; e.addr = a; e.wdata = wd;
      issue_q.push_back(e);
   endtask

   task automatic expect_resp(input bit is_d, input logic [15:0] data);
      rsp_t r;
      r.is_d = is_d; r.data = data;
      resp_q.push_back(r);
   endtask

   task automatic gap(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   task automatic chk_zero(input string name);
      chk(name, {8'h00, mem_req, mem_we, mem_addr, mem_wdata, i_ack, d_ack,
                 i_rdata, d_rdata, busy, err_spurious}, 64'h0);
   endtask

   // Called at #1 after an edge; returns cycles until i_ack was seen.
   task automatic fetch(input logic [15:0] a, output int cyc);
      i_req  = 1'b1;
      i_addr = a;
      cyc    = 0;
      while (cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (i_ack) break;
      end
      if (!i_ack) chk("fetch_timeout", 64'(cyc), 64'h0);
      i_req = 1'b0;
   endtask

   task automatic d_txn(input logic we, input logic [15:0] a, input logic [15:0] wd);
      int cyc;
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = a;
      d_wdata = wd;
      cyc     = 0;
      while (cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
         if (d_ack) break;
      end
      if (!d_ack) chk("dtxn_timeout", 64'(cyc), 64'h0);
      d_req = 1'b0;
   endtask

   initial begin
      int c, c1, c2, k;
      bit bad;
      mem[16'h0005] = 16'hE000; mem[16'h0003] = 16'hC003; mem[16'h0020] = 16'hA020;
      mem[16'h0030] = 16'h3030; mem[16'h0031] = 16'h3131; mem[16'h0032] = 16'h3232;
      mem[16'h0033] = 16'h3333; mem[16'h0006] = 16'hE006; mem[16'h0007] = 16'hE007;
      mem[16'h0040] = 16'h4040; mem[16'h0041] = 16'h4141;
      reset = 1'b1; halt = 1'b0; i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      gap(3);
      chk_zero("reset_state");
      reset = 1'b0;
      gap(2);

      // Single fetch
      expect_issue(1'b0, 16'h0005, 16'h0000);
      expect_resp(1'b0, 16'hE000);
      fetch(16'h0005, c);
      gap(2);

      // Store leaves d_rdata at 0
      expect_issue(1'b1, 16'h0010, 16'h1234);
      expect_resp(1'b1, 16'h0000);
      d_txn(1'b1, 16'h0010, 16'h1234);
      chk("store_mem", 64'(mem[16'h0010]), 64'h1234);
      gap(2);

      // Simultaneous requests: D before I
      expect_issue(1'b0, 16'h0020, 16'h0000);
      expect_issue(1'b0, 16'h0003, 16'h0000);
      expect_resp(1'b1, 16'hA020);
      expect_resp(1'b0, 16'hC003);
      fork
         fetch(16'h0003, c);
         d_txn(1'b0, 16'h0020, 16'h0000);
      join
      gap(2);

      // Continuous D with pending I: D, D, I, D, D, I
      expect_issue(1'b0, 16'h0030, 16'h0); expect_resp(1'b1, 16'h3030);
      expect_issue(1'b0, 16'h0031, 16'h0); expect_resp(1'b1, 16'h3131);
      expect_issue(1'b0, 16'h0006, 16'h0); expect_resp(1'b0, 16'hE006);
      expect_issue(1'b0, 16'h0032, 16'h0); expect_resp(1'b1, 16'h3232);
      expect_issue(1'b0, 16'h0033, 16'h0); expect_resp(1'b1, 16'h3333);
      expect_issue(1'b0, 16'h0007, 16'h0); expect_resp(1'b0, 16'hE007);
      fork
         begin
            fetch(16'h0006, c1);
            chk("starve_bound", 64'(c1 <= 12), 64'h1);
            fetch(16'h0007, c2);
         end
         begin
            d_txn(1'b0, 16'h0030, 16'h0);
            d_txn(1'b0, 16'h0031, 16'h0);
            d_txn(1'b0, 16'h0032, 16'h0);
            d_txn(1'b0, 16'h0033, 16'h0);
         end
      join
      gap(2);

      // Halt blocks fetch but not data
      halt = 1'b1; i_req = 1'b1; i_addr = 16'h0040; bad = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (mem_req || busy) bad = 1'b1;
      end
      chk("halt_idle", 64'(bad), 64'h0);
      expect_issue(1'b0, 16'h0041, 16'h0); expect_resp(1'b1, 16'h4141);
      d_txn(1'b0, 16'h0041, 16'h0);
      gap(1);
      halt = 1'b0;
      expect_issue(1'b0, 16'h0040, 16'h0); expect_resp(1'b0, 16'h4040);
      fetch(16'h0040, c);
      gap(2);

      // Halt rising mid-fetch: fetch still completes
      expect_issue(1'b0, 16'h0005, 16'h0); expect_resp(1'b0, 16'hE000);
      fork
         fetch(16'h0005, c);
         begin
            k = 0;
            while (!mem_req && k < 50) begin @(posedge clk); #1; k++; end
            halt = 1'b1;
         end
      join
      chk("halt_inflight_busy", 64'(busy), 64'h0);
      halt = 1'b0;
      gap(2);

      // Reset mid-transaction, then a spurious mem_done
      mem_auto = 1'b0;
      expect_issue(1'b0, 16'h0050, 16'h0);
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0050;
      k = 0;
      while (!mem_req && k < 50) begin @(posedge clk); #1; k++; end
      chk("busy_d", 64'(busy), 64'h1);
      reset = 1'b1; d_req = 1'b0;
      gap(1);
      chk_zero("reset_mid");
      reset = 1'b0;
      gap(3);
      chk("no_ack_after_reset", 64'({d_ack, busy}), 64'h0);
      @(posedge clk); #2;
      mem_done = 1'b1;
      @(posedge clk); #2;
      chk("err_set", 64'(err_spurious), 64'h1);
      gap(5);
      chk("err_sticky", 64'({err_spurious, busy, i_ack, d_ack}), 64'h8);
      reset = 1'b1;
      gap(1);
      chk("err_cleared", 64'(err_spurious), 64'h0);
      reset = 1'b0;
      gap(2);

      chk("issue_q_empty", 64'(issue_q.size()), 64'h0);
      chk("resp_q_empty", 64'(resp_q.size()), 64'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1);
   end

endmodule

`default_nettype wire
